eq_sample_sequencer: RTL and testbench
======================================

// Module: eq_sample_sequencer
// PURPOSE
// Playback controller between the sample ROM and the LPF in the equalizer datapath.
// On a start request it walks a configurable address window of the synchronous ROM.
// It forwards each sample to the filter with a valid strobe.
// It then flushes the filter with ORDER zero samples so the tail of the response drains.
// It reports busy/done to the top level.
// PARAMETERS
// ADDR_WIDTH  10  ROM address bits; the address wraps modulo 2**ADDR_WIDTH
// DATA_WIDTH   8  ROM sample width; equals the filter word_size_in
// ORDER       32  filter order; number of zero samples emitted during flush
// PORTS
// clk          in   1             system clock, rising edge
// reset        in   1             asynchronous, active-low reset
// start        in   1             run request; sampled only in IDLE
// pause        in   1             stall; freezes address issue and flush count
// start_addr   in   ADDR_WIDTH    first ROM address of the run; latched on accepted start
// num_samples  in   ADDR_WIDTH+1  samples in the run (0..2**ADDR_WIDTH); latched on accepted start
// rom_addr     out  ADDR_WIDTH    address to the synchronous ROM
// rom_data     in   DATA_WIDTH    ROM read data; reflects the rom_addr sampled at the previous edge
// fir_data     out  DATA_WIDTH    registered sample to the filter
// fir_valid    out  1             fir_data is a new sample this cycle
// busy         out  1             high in RUN and FLUSH
// done         out  1             one-cycle pulse at end of run
// BEHAVIOUR
// - Reset low (async): state=IDLE; rom_addr, fir_data, fir_valid, busy, done, counters and pipe bit all 0, immediately.
// - FSM states: IDLE, RUN, FLUSH, DONE.
//   - IDLE: start=1 and num_samples!=0 -> RUN. On that edge: rom_addr<=start_addr, remaining<=num_samples.
//   - IDLE: start=1 and num_samples==0 -> DONE.
//   - IDLE: otherwise stay.
//   - RUN: an issue occurs on each edge with pause=0. On an issue: pipe<=1 and remaining--.
//     rom_addr<=rom_addr+1 (wraps 2**ADDR_WIDTH-1 -> 0) unless this is the last issue; after the last issue rom_addr holds.
//     The last issue (remaining==1) -> FLUSH.
//   - RUN with pause=1: no issue; pipe<=0; rom_addr and remaining hold.
//   - FLUSH: emits ORDER zeros, one per non-paused cycle, after the last real sample has left the pipe.
//     The zeros follow the last real sample with no gap when pause=0. After the ORDER-th zero -> DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE. No fir_valid is asserted in DONE.
// - Data path latency: if address A is issued at edge N, then at edge N+1 pipe=1 and fir_data<=rom_data (=mem[A]), fir_valid<=1.
//   fir_valid is therefore high in the cycle after edge N+1, i.e. two cycles after A was on rom_addr.
// - fir_valid=0 whenever no real or flush sample is presented. fir_data holds its last value when fir_valid=0.
//   Flush samples drive fir_data=0.
// - Per run, fir_valid pulses total exactly num_samples+ORDER, in ROM order then zeros; no sample is dropped or duplicated.
// - pause: affects only future issues and flush counting. An already-issued sample is still delivered.
// - start while busy or in DONE is ignored; start_addr and num_samples changes during a run have no effect.
// - start held high continuously: a new run begins on the first IDLE cycle after DONE.
// - num_samples==2**ADDR_WIDTH: each ROM address is read exactly once, starting and ending adjacent to start_addr.
// - busy = (state==RUN || state==FLUSH), registered with the state. done and busy are never high together.
// TESTING
// 1. start_addr=0, num_samples=4, ROM={11,22,33,44}, pause=0 -> rom_addr 0,1,2,3.
//    fir_valid is high for 36 consecutive cycles: data 11,22,33,44 then 32 zeros. done pulses once, 1 cycle after the last zero.
// 2. start_addr=1022, num_samples=4 -> rom_addr 1022,1023,0,1; fir_data = mem[1022],mem[1023],mem[0],mem[1].
// 3. num_samples=10; pause=1 for 3 cycles after the 5th issue -> rom_addr frozen 3 cycles.
//    One in-flight sample is still delivered, then a 3-cycle fir_valid gap; total valids=42, order preserved.
// 4. num_samples=0, start=1 -> done high the cycle after the next edge; busy and fir_valid stay 0.
// 5. reset low during FLUSH -> all outputs 0 immediately.
//    After reset high, start_addr=5, num_samples=2 -> a clean run: mem[5], mem[6], 32 zeros.
// 6. start re-pulsed while busy, with a new start_addr -> ignored; the run completes with the original window and one done pulse.

Source files
------------

// File: rtl/eq_sample_sequencer.sv
// Playback controller: walks a window of the synchronous sample ROM, forwards each
// sample to the filter with a valid strobe, then flushes the filter with ORDER zeros.
module eq_sample_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ORDER      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  pause_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   num_samples_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] fir_data_o,
    output logic                  fir_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = $clog2(ORDER + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [CW-1:0]         flushCnt_q, flushCnt_d;
    logic                  pipe_q, pipe_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        flushCnt_d  = flushCnt_q;
        pipe_d      = 1'b0;
        data_d      = data_q;
        valid_d     = 1'b0;

        // An issued address always lands one edge later, whatever the state or pause.
        if (pipe_q) begin
            data_d  = rom_data_i;
            valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (num_samples_i != '0) begin
                        state_d     = S_RUN;
                        addr_d      = start_addr_i;
                        remaining_d = num_samples_i;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (!pause_i) begin
                    pipe_d      = 1'b1;
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d    = S_FLUSH;
                        flushCnt_d = '0;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FLUSH: begin
                // Leave only on the edge after the last zero so DONE never overlaps a valid.
                if (flushCnt_q == CW'(ORDER)) begin
                    state_d = S_DONE;
                end else if (!pipe_q && !pause_i) begin
                    data_d     = '0;
                    valid_d    = 1'b1;
                    flushCnt_d = flushCnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            flushCnt_q  <= '0;
            pipe_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            flushCnt_q  <= flushCnt_d;
            pipe_q      <= pipe_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign rom_addr_o  = addr_q;
    assign fir_data_o  = data_q;
    assign fir_valid_o = valid_q;
    assign busy_o      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_eq_sample_sequencer.sv
// Directed bench for eq_sample_sequencer: a behavioural synchronous ROM plus a
// negedge monitor that collects the filter stream for comparison with hand-built expectations.
module tb_eq_sample_sequencer;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int ORDER = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          pause;
    logic [AW-1:0] startAddr;
    logic [AW:0]   numSamples;
    logic [AW-1:0] romAddr;
    logic [DW-1:0] romData;
    logic [DW-1:0] firData;
    logic          firValid;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    logic          collecting = 1'b0;
    logic [DW-1:0] gotQ [$];
    logic [DW-1:0] expQ [$];
    int doneCnt, bothHigh, maxRun, curRun, gapTotal, pendingGap;
    int cycleIdx, lastValidCyc, doneCyc;
    bit seenFirst;

    eq_sample_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ORDER(ORDER)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .pause_i      (pause),
        .start_addr_i (startAddr),
        .num_samples_i(numSamples),
        .rom_addr_o   (romAddr),
        .rom_data_i   (romData),
        .fir_data_o   (firData),
        .fir_valid_o  (firValid),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) romData <= mem[romAddr];

    // Stream monitor: records every valid sample plus run-length, gap and done timing.
    always @(negedge clk) begin
        if (collecting) begin
            cycleIdx = cycleIdx + 1;
            if (done && busy) bothHigh = bothHigh + 1;
            if (done) begin
                doneCnt = doneCnt + 1;
                doneCyc = cycleIdx;
            end
            if (firValid) begin
                gotQ.push_back(firData);
                if (seenFirst) gapTotal = gapTotal + pendingGap;
                pendingGap   = 0;
                seenFirst    = 1'b1;
                curRun       = curRun + 1;
                if (curRun > maxRun) maxRun = curRun;
                lastValidCyc = cycleIdx;
            end else begin
                curRun = 0;
                if (seenFirst) pendingGap = pendingGap + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic startCollect();
        gotQ.delete();
        expQ.delete();
        doneCnt = 0; bothHigh = 0; maxRun = 0; curRun = 0; gapTotal = 0; pendingGap = 0;
        cycleIdx = 0; lastValidCyc = -1; doneCyc = -1; seenFirst = 1'b0;
        collecting = 1'b1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] sa, input logic [AW:0] ns);
        @(negedge clk);
        startAddr  = sa;
        numSamples = ns;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (doneCnt == 0 && n < 3000) begin
            @(posedge clk);
            n = n + 1;
        end
        if (doneCnt == 0) checkOutput({tag, "_timeout"}, 0, 1);
        repeat (4) @(posedge clk);
        collecting = 1'b0;
    endtask

    task automatic buildExpect(input logic [AW-1:0] sa, input int ns);
        logic [AW-1:0] a;
        a = sa;
        for (int i = 0; i < ns; i++) begin
            expQ.push_back(mem[a]);
            a = a + AW'(1);
        end
        for (int i = 0; i < ORDER; i++) expQ.push_back('0);
    endtask

    task automatic compareStream(input string tag);
        checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
        if (gotQ.size() == expQ.size()) begin
            for (int i = 0; i < expQ.size(); i++) begin
                if (gotQ[i] !== expQ[i]) checkOutput($sformatf("%s_data%0d", tag, i), gotQ[i], expQ[i]);
            end
        end
        checkOutput({tag, "_dones"}, doneCnt, 1);
        checkOutput({tag, "_doneBusy"}, bothHigh, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 37 + 5);
        mem[0] = 8'd11; mem[1] = 8'd22; mem[2] = 8'd33; mem[3] = 8'd44;
        start = 1'b0; pause = 1'b0; startAddr = '0; numSamples = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstAddr", romAddr, 0);
        checkOutput("rstValid", firValid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        rst_n = 1'b1;

        // 1: basic run, contiguous 36-valid stream and done one cycle after last zero
        startCollect();
        buildExpect(10'd0, 4);
        applyStimulus(10'd0, 11'd4);
        checkOutput("t1_busy", busy, 1);
        waitDone("t1");
        compareStream("t1");
        checkOutput("t1_run", maxRun, 36);
        checkOutput("t1_doneLag", doneCyc - lastValidCyc, 1);

        // 2: address wrap
        startCollect();
        buildExpect(10'd1022, 4);
        applyStimulus(10'd1022, 11'd4);
        waitDone("t2");
        compareStream("t2");

        // 3: pause after the 5th issue
        startCollect();
        buildExpect(10'd40, 10);
        @(negedge clk);
        startAddr = 10'd40; numSamples = 11'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t3_frozen%0d", i), romAddr, 45);
        end
        pause = 1'b0;
        waitDone("t3");
        compareStream("t3");
        checkOutput("t3_gap", gapTotal, 3);

        // 4: empty run goes straight to done
        @(negedge clk);
        numSamples = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t4_done", done, 1);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_valid", firValid, 0);
        @(negedge clk);
        checkOutput("t4_doneOff", done, 0);

        // 5: reset in the middle of flush, then a clean run
        startCollect();
        applyStimulus(10'd0, 11'd4);
        begin
            int n;
            n = 0;
            while (gotQ.size() < 8 && n < 500) begin
                @(posedge clk);
                n = n + 1;
            end
            if (gotQ.size() < 8) checkOutput("t5_reachFlush", 0, 1);
        end
        collecting = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_addr", romAddr, 0);
        checkOutput("t5_data", firData, 0);
        checkOutput("t5_valid", firValid, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        startCollect();
        buildExpect(10'd5, 2);
        applyStimulus(10'd5, 11'd2);
        waitDone("t5");
        compareStream("t5");

        // 6: start re-pulsed mid-run with a different window is ignored
        startCollect();
        buildExpect(10'd100, 3);
        applyStimulus(10'd100, 11'd3);
        applyStimulus(10'd200, 11'd7);
        waitDone("t6");
        compareStream("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
